// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packet sequencer.
// The CRC helpers are only referenced when USB_TX_CRC16_EN is defined.
package usb_tx_pkg;

  // Sequencer states. The PID byte is loaded in the same cycle txStart is
  // accepted, so the FSM passes from IDLE straight to the body state; PID
  // names that step and is never held in the state register.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PID       = 3'd1,
    DATA      = 3'd2,
    CRC_LO    = 3'd3,
    CRC_HI    = 3'd4,
    WAIT_LAST = 3'd5
  } txState_t;

  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

  // One reflected CRC16 step for a single serial bit.
  function automatic logic [15:0] crc16Step(input logic [15:0] crc, input logic dataBit);
    logic feedback;
    feedback = crc[0] ^ dataBit;
    if (feedback) begin
      crc16Step = {1'b0, crc[15:1]} ^ CRC16_POLY_REFL;
    end else begin
      crc16Step = {1'b0, crc[15:1]};
    end
  endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational CRC16 (0x8005 reflected) update for one byte, LSB first.
// Only instantiated by the sequencer when USB_TX_CRC16_EN is defined.
module usb_crc16_byte
  import usb_tx_pkg::*;
(
  input  logic [15:0] crcIn,
  input  logic [7:0]  dataIn,
  output logic [15:0] crcOut
);

  logic [15:0] step1;
  logic [15:0] step2;
  logic [15:0] step3;
  logic [15:0] step4;
  logic [15:0] step5;
  logic [15:0] step6;
  logic [15:0] step7;

  // Eight unrolled bit steps, bit 0 of the byte enters first.
  assign step1  = crc16Step(crcIn, dataIn[0]);
  assign step2  = crc16Step(step1, dataIn[1]);
  assign step3  = crc16Step(step2, dataIn[2]);
  assign step4  = crc16Step(step3, dataIn[3]);
  assign step5  = crc16Step(step4, dataIn[4]);
  assign step6  = crc16Step(step5, dataIn[5]);
  assign step7  = crc16Step(step6, dataIn[6]);
  assign crcOut = crc16Step(step7, dataIn[7]);

endmodule

// File: rtl/usb_tx_pkt_sequencer.sv
// USB transmit packet sequencer: PID, FIFO data bytes and optional CRC16
// streamed into the SIE through a single-entry output register, with
// underrun detection and completion status.
// Optional feature macro: USB_TX_CRC16_EN appends the inverted CRC16
// (low byte first); without it the last data byte (or the PID of a
// zero-length packet) carries sieLast.
module usb_tx_pkt_sequencer
  import usb_tx_pkg::*;
#(
  parameter int LEN_WIDTH        = 10,
  parameter int UNDERRUN_TIMEOUT = 8
) (
  input  logic                 usbClk,
  input  logic                 rstN,
  input  logic                 txStart,
  input  logic [3:0]           txPid,
  input  logic [LEN_WIDTH-1:0] txLength,
  input  logic                 fifoEmpty,
  input  logic [7:0]           fifoDataOut,
  output logic                 fifoREn,
  output logic [7:0]           sieByte,
  output logic                 sieValid,
  output logic                 sieLast,
  input  logic                 sieReady,
  output logic                 sieAbort,
  output logic                 txBusy,
  output logic                 txDone,
  output logic                 txUnderrun
);

  localparam int STALL_W = $clog2(UNDERRUN_TIMEOUT + 1);
  localparam logic [STALL_W-1:0]   STALL_ONE   = STALL_W'(1);
  localparam logic [STALL_W-1:0]   STALL_ZERO  = STALL_W'(0);
  localparam logic [STALL_W-1:0]   STALL_LIMIT = STALL_W'(UNDERRUN_TIMEOUT);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE     = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO    = LEN_WIDTH'(0);

  txState_t             state;
  txState_t             stateNxt;
  logic [LEN_WIDTH-1:0] remaining;
  logic [LEN_WIDTH-1:0] remainingNxt;
  logic [STALL_W-1:0]   stallCnt;
  logic [STALL_W-1:0]   stallCntNxt;
  logic [STALL_W-1:0]   stallInc;
  logic [7:0]           sieByteNxt;
  logic                 sieValidNxt;
  logic                 sieLastNxt;
  logic                 sieAbortNxt;
  logic                 txBusyNxt;
  logic                 txDoneNxt;
  logic                 txUnderrunNxt;
  logic                 canLoad;
  logic                 popNow;

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc;
  logic [15:0] crcNxt;
  logic [15:0] crcWithByte;

  usb_crc16_byte uCrc16 (
    .crcIn  (crc),
    .dataIn (fifoDataOut),
    .crcOut (crcWithByte)
  );
`endif

  // The output register may take a new byte when it is empty or drained now.
  assign canLoad  = !sieValid || sieReady;
  assign stallInc = stallCnt + STALL_ONE;
  // The pop is combinational so the FIFO head advances on the load edge.
  assign fifoREn  = popNow;

  // Next-state, output-register and status decisions.
  always_comb begin
    stateNxt      = state;
    remainingNxt  = remaining;
    stallCntNxt   = stallCnt;
    sieByteNxt    = sieByte;
    sieValidNxt   = sieValid;
    sieLastNxt    = sieLast;
    sieAbortNxt   = 1'b0;
    txBusyNxt     = txBusy;
    txDoneNxt     = 1'b0;
    txUnderrunNxt = 1'b0;
    popNow        = 1'b0;
`ifdef USB_TX_CRC16_EN
    crcNxt        = crc;
`endif

    // An accepted byte leaves the register empty unless reloaded below.
    if (sieValid && sieReady) begin
      sieValidNxt = 1'b0;
      sieLastNxt  = 1'b0;
    end else begin
      sieValidNxt = sieValid;
      sieLastNxt  = sieLast;
    end

    case (state)
      IDLE: begin
        if (txStart) begin
          sieByteNxt   = {~txPid, txPid};
          sieValidNxt  = 1'b1;
          txBusyNxt    = 1'b1;
          remainingNxt = txLength;
          stallCntNxt  = STALL_ZERO;
`ifdef USB_TX_CRC16_EN
          crcNxt       = CRC16_INIT;
`endif
          if (txLength != LEN_ZERO) begin
            sieLastNxt = 1'b0;
            stateNxt   = DATA;
          end else begin
`ifdef USB_TX_CRC16_EN
            sieLastNxt = 1'b0;
            stateNxt   = CRC_LO;
`else
            sieLastNxt = 1'b1;
            stateNxt   = WAIT_LAST;
`endif
          end
        end else begin
          stateNxt = IDLE;
        end
      end

      DATA: begin
        if (canLoad) begin
          if (!fifoEmpty) begin
            popNow       = 1'b1;
            sieByteNxt   = fifoDataOut;
            sieValidNxt  = 1'b1;
            remainingNxt = remaining - LEN_ONE;
            stallCntNxt  = STALL_ZERO;
`ifdef USB_TX_CRC16_EN
            crcNxt       = crcWithByte;
`endif
            if (remaining == LEN_ONE) begin
`ifdef USB_TX_CRC16_EN
              sieLastNxt = 1'b0;
              stateNxt   = CRC_LO;
`else
              sieLastNxt = 1'b1;
              stateNxt   = WAIT_LAST;
`endif
            end else begin
              sieLastNxt = 1'b0;
              stateNxt   = DATA;
            end
          end else if (stallInc == STALL_LIMIT) begin
            // Starved too long: the SIE must drop what it has already seen.
            sieAbortNxt   = 1'b1;
            txUnderrunNxt = 1'b1;
            sieValidNxt   = 1'b0;
            sieLastNxt    = 1'b0;
            txBusyNxt     = 1'b0;
            stallCntNxt   = STALL_ZERO;
            stateNxt      = IDLE;
          end else begin
            stallCntNxt = stallInc;
            stateNxt    = DATA;
          end
        end else begin
          stateNxt = DATA;
        end
      end

`ifdef USB_TX_CRC16_EN
      CRC_LO: begin
        if (canLoad) begin
          sieByteNxt  = ~crc[7:0];
          sieValidNxt = 1'b1;
          sieLastNxt  = 1'b0;
          stateNxt    = CRC_HI;
        end else begin
          stateNxt = CRC_LO;
        end
      end

      CRC_HI: begin
        if (canLoad) begin
          sieByteNxt  = ~crc[15:8];
          sieValidNxt = 1'b1;
          sieLastNxt  = 1'b1;
          stateNxt    = WAIT_LAST;
        end else begin
          stateNxt = CRC_HI;
        end
      end
`endif

      WAIT_LAST: begin
        if (sieValid && sieReady) begin
          txDoneNxt = 1'b1;
          txBusyNxt = 1'b0;
          stateNxt  = IDLE;
        end else begin
          stateNxt = WAIT_LAST;
        end
      end

      default: begin
        txBusyNxt = 1'b0;
        stateNxt  = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge usbClk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  // Output stage, status pulses and packet bookkeeping registers.
  always_ff @(posedge usbClk or negedge rstN) begin
    if (!rstN) begin
      sieByte    <= 8'h00;
      sieValid   <= 1'b0;
      sieLast    <= 1'b0;
      sieAbort   <= 1'b0;
      txBusy     <= 1'b0;
      txDone     <= 1'b0;
      txUnderrun <= 1'b0;
      remaining  <= LEN_ZERO;
      stallCnt   <= STALL_ZERO;
    end else begin
      sieByte    <= sieByteNxt;
      sieValid   <= sieValidNxt;
      sieLast    <= sieLastNxt;
      sieAbort   <= sieAbortNxt;
      txBusy     <= txBusyNxt;
      txDone     <= txDoneNxt;
      txUnderrun <= txUnderrunNxt;
      remaining  <= remainingNxt;
      stallCnt   <= stallCntNxt;
    end
  end

`ifdef USB_TX_CRC16_EN
  // Running CRC over the data bytes of the current packet.
  always_ff @(posedge usbClk or negedge rstN) begin
    if (!rstN) begin
      crc <= CRC16_INIT;
    end else begin
      crc <= crcNxt;
    end
  end
`endif

endmodule

// File: tb/tb_usb_tx_pkt_sequencer.sv
// Scoreboard bench for usb_tx_pkt_sequencer: expected SIE bytes are queued
// when a packet is issued and a monitor pops and compares them on every
// handshake. Follows USB_TX_CRC16_EN to decide whether CRC bytes are expected.
module tb_usb_tx_pkt_sequencer;

  localparam int LW = 10;
  localparam int TO = 8;

  logic          usbClk = 1'b0;
  logic          rstN = 1'b0;
  logic          txStart = 1'b0;
  logic [3:0]    txPid = 4'h0;
  logic [LW-1:0] txLength = '0;
  logic          fifoEmpty = 1'b1;
  logic [7:0]    fifoDataOut = 8'h00;
  logic          fifoREn;
  logic [7:0]    sieByte;
  logic          sieValid;
  logic          sieLast;
  logic          sieReady = 1'b1;
  logic          sieAbort;
  logic          txBusy;
  logic          txDone;
  logic          txUnderrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] fifoQ[$];
  logic [7:0] dataQ[$];
  logic [8:0] expQ[$];
  logic popPending = 1'b0;
  logic doneDue = 1'b0;
  int popCount = 0;
  int doneCount = 0;
  int abortCount = 0;
  int expAbortCycle = -1;
  int readyMode = 1;
  int starveMode = 0;
  int starveRun = 0;
  logic starveNow = 1'b0;

  usb_tx_pkt_sequencer #(.LEN_WIDTH(LW), .UNDERRUN_TIMEOUT(TO)) dut (
    .usbClk      (usbClk),
    .rstN        (rstN),
    .txStart     (txStart),
    .txPid       (txPid),
    .txLength    (txLength),
    .fifoEmpty   (fifoEmpty),
    .fifoDataOut (fifoDataOut),
    .fifoREn     (fifoREn),
    .sieByte     (sieByte),
    .sieValid    (sieValid),
    .sieLast     (sieLast),
    .sieReady    (sieReady),
    .sieAbort    (sieAbort),
    .txBusy      (txBusy),
    .txDone      (txDone),
    .txUnderrun  (txUnderrun)
  );

  always #5 usbClk = ~usbClk;

  always @(posedge usbClk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge usbClk);
  endtask

  // FIFO model and SIE ready pattern, updated away from the clock edge.
  always @(negedge usbClk) begin
    if (popPending) begin
      if (fifoQ.size() > 0) void'(fifoQ.pop_front());
      popPending = 1'b0;
    end
    if (starveMode != 0 && starveRun < 3 && $urandom_range(3, 0) == 0) starveNow = 1'b1;
    else starveNow = 1'b0;
    starveRun = starveNow ? starveRun + 1 : 0;
    fifoEmpty   = (fifoQ.size() == 0) || starveNow;
    fifoDataOut = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
    case (readyMode)
      0:       sieReady = 1'($urandom_range(1, 0));
      2:       sieReady = ~sieReady;
      default: sieReady = 1'b1;
    endcase
  end

  // Monitor: compares every presented handshake and status pulse.
  always @(negedge usbClk) begin
    logic [8:0] e;
    #2;
    if (rstN) begin
      if (txDone || doneDue) begin
        total++;
        if (txDone !== doneDue) begin
          bad++;
          $display("FAIL txDone: got %b want %b (cycle %0d)", txDone, doneDue, cyc);
        end
      end
      doneDue = 1'b0;
      if (txDone) doneCount++;
      if (sieAbort || txUnderrun || cyc == expAbortCycle) begin
        total++;
        if (sieAbort !== (cyc == expAbortCycle) || txUnderrun !== (cyc == expAbortCycle) || sieValid !== 1'b0) begin
          bad++;
          $display("FAIL abort: got abort=%b underrun=%b valid=%b want abort at cycle %0d (cycle %0d)",
                   sieAbort, txUnderrun, sieValid, expAbortCycle, cyc);
        end
      end
      if (sieAbort) abortCount++;
      if (fifoREn) begin
        total++;
        if (fifoEmpty || (sieValid && !sieReady) || !txBusy) begin
          bad++;
          $display("FAIL pop: got pop with empty=%b valid=%b ready=%b busy=%b want no pop (cycle %0d)",
                   fifoEmpty, sieValid, sieReady, txBusy, cyc);
        end
        popPending = 1'b1;
        popCount++;
      end
      if (sieValid && sieReady) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("FAIL byte: got %h last=%b want nothing (cycle %0d)", sieByte, sieLast, cyc);
        end else begin
          e = expQ.pop_front();
          if ({sieLast, sieByte} !== e) begin
            bad++;
            $display("FAIL byte: got last=%b %h want last=%b %h (cycle %0d)", sieLast, sieByte, e[8], e[7:0], cyc);
          end
        end
        doneDue = sieLast;
      end
    end
  end

  // Reference packet: PID, data bytes, then CRC16/USB when enabled.
  task automatic buildExp(input logic [3:0] pid, input int len, input int nAvail, input bit abort);
    logic [15:0] c;
    int nBody;
    bit crcOn;
`ifdef USB_TX_CRC16_EN
    crcOn = 1'b1;
`else
    crcOn = 1'b0;
`endif
    nBody = abort ? nAvail : len;
    expQ.delete();
    expQ.push_back({(!abort && len == 0 && !crcOn), ~pid, pid});
    c = 16'hFFFF;
    for (int i = 0; i < nBody; i++) begin
      c = c ^ {8'h00, dataQ[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      expQ.push_back({(!abort && i == len - 1 && !crcOn), dataQ[i]});
    end
    if (!abort && crcOn) begin
      c = ~c;
      expQ.push_back({1'b0, c[7:0]});
      expQ.push_back({1'b1, c[15:8]});
    end
  endtask

  task automatic startPkt(input logic [3:0] pid, input int len, input bit abort);
    fifoQ.delete();
    foreach (dataQ[i]) fifoQ.push_back(dataQ[i]);
    buildExp(pid, len, dataQ.size(), abort);
    tick(1);
    popCount = 0;
    doneCount = 0;
    abortCount = 0;
    txPid = pid;
    txLength = LW'(len);
    txStart = 1'b1;
    if (abort) expAbortCycle = cyc + 1 + dataQ.size() + TO;
    tick(1);
    txStart = 1'b0;
    check("pid valid next cycle", sieValid, 1);
    check("busy after start", txBusy, 1);
  endtask

  task automatic finishPkt(input int len, input bit abort, input bit poke);
    bit fin = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (poke && k == 3) begin
        check("busy at ignored start", txBusy, 1);
        txPid = 4'hF;
        txLength = LW'(3);
        txStart = 1'b1;
      end else begin
        txStart = 1'b0;
      end
      if (!txBusy && expQ.size() == 0) begin
        fin = 1'b1;
        break;
      end
      tick(1);
    end
    txStart = 1'b0;
    check("packet finished", fin, 1);
    tick(2);
    check("busy cleared", txBusy, 0);
    check("expected bytes drained", expQ.size(), 0);
    check("pop count", popCount, abort ? dataQ.size() : len);
    check("done pulses", doneCount, abort ? 0 : 1);
    check("abort pulses", abortCount, abort ? 1 : 0);
    expAbortCycle = -1;
  endtask

  task automatic runPkt(input logic [3:0] pid, input int len, input bit abort, input bit poke);
    startPkt(pid, len, abort);
    finishPkt(len, abort, poke);
  endtask

  task automatic fillRandom(input int n);
    dataQ.delete();
    for (int i = 0; i < n; i++) dataQ.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " sieValid"}, sieValid, 0);
    check({tag, " sieByte"}, sieByte, 0);
    check({tag, " sieLast"}, sieLast, 0);
    check({tag, " fifoREn"}, fifoREn, 0);
    check({tag, " txBusy"}, txBusy, 0);
    check({tag, " txDone"}, txDone, 0);
    check({tag, " sieAbort"}, sieAbort, 0);
    check({tag, " txUnderrun"}, txUnderrun, 0);
  endtask

  initial begin
    int len;
    rstN = 1'b0;
    tick(3);
    checkAllZero("reset");
    rstN = 1'b1;
    tick(2);

    // Zero-length packet.
    dataQ.delete();
    runPkt(4'h3, 0, 1'b0, 1'b0);

    // "123456789" with SIE always ready, then with ready toggling.
    dataQ = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    runPkt(4'hB, 9, 1'b0, 1'b0);
    readyMode = 2;
    runPkt(4'hB, 9, 1'b0, 1'b0);
    readyMode = 1;

    // Underrun: only two bytes for a five-byte packet.
    dataQ = {8'hA5, 8'h5A};
    runPkt(4'h1, 5, 1'b1, 1'b0);

    // A second start while busy must be ignored.
    fillRandom(12);
    runPkt(4'h9, 12, 1'b0, 1'b1);

    // Reset in the middle of DATA, then a clean packet.
    fillRandom(30);
    startPkt(4'h4, 30, 1'b0);
    tick(5);
    #3;
    rstN = 1'b0;
    #1;
    checkAllZero("mid-packet reset");
    expQ.delete();
    fifoQ.delete();
    doneDue = 1'b0;
    popPending = 1'b0;
    tick(2);
    rstN = 1'b1;
    tick(2);
    fillRandom(7);
    runPkt(4'h6, 7, 1'b0, 1'b0);

    // Randomized packets with random SIE back-pressure and short FIFO stalls.
    for (int n = 0; n < 12; n++) begin
      readyMode = $urandom_range(2, 0);
      starveMode = $urandom_range(1, 0);
      len = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(40, 1));
      fillRandom(len + int'($urandom_range(2, 0)));
      runPkt(4'($urandom_range(15, 0)), len, 1'b0, 1'b0);
    end
    readyMode = 1;
    starveMode = 0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
